// File: rtl/axi_lite_reg_slv_pkg.sv
// Shared widths, response codes and AXI4-Lite request/response payload structs
// used by the register-bank responder.
package axi_lite_reg_slv_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_PROT_W = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_PROT_W-1:0] prot;
  } ax_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } axi_lite_resp_t;

endpackage

// File: rtl/axi_lite_reg_slv_rsp_hold.sv
// Holds one response channel's valid flag and payload from accept until the
// master takes it with ready.
module axi_lite_reg_slv_rsp_hold #(
  parameter type payload_t = logic
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     accept_i,
  input  payload_t payload_i,
  input  logic     ready_i,
  output logic     valid_o,
  output payload_t payload_o
);

  logic     valid_d, valid_q;
  payload_t payload_d, payload_q;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (accept_i) begin
      valid_d   = 1'b1;
      payload_d = payload_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/axi_lite_reg_slv.sv
// AXI4-Lite responder over a byte-addressable register bank with per-byte
// strobes, read-only bytes, PROT filtering and direct hardware byte loads.
module axi_lite_reg_slv
  import axi_lite_reg_slv_pkg::*;
#(
  parameter int unsigned                 RegNumBytes  = 32,
  parameter int unsigned                 AxiAddrWidth = AXI_ADDR_W,
  parameter int unsigned                 AxiDataWidth = AXI_DATA_W,
  parameter logic                        PrivProtOnly = 1'b0,
  parameter logic                        SecuProtOnly = 1'b0,
  parameter logic [RegNumBytes-1:0]      AxiReadOnly  = '0,
  parameter logic [RegNumBytes-1:0][7:0] RegRstVal    = '0,
  parameter type                         req_lite_t   = axi_lite_req_t,
  parameter type                         resp_lite_t  = axi_lite_resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  req_lite_t                  axi_req_i,
  output resp_lite_t                 axi_resp_o,
  output logic [RegNumBytes-1:0]     wr_active_o,
  output logic [RegNumBytes-1:0]     rd_active_o,
  input  logic [RegNumBytes*8-1:0]   reg_d_i,
  input  logic [RegNumBytes-1:0]     reg_load_i,
  output logic [RegNumBytes*8-1:0]   reg_q_o
);

  localparam int unsigned StrbW    = AxiDataWidth / 8;
  localparam int unsigned AddrLsb  = $clog2(StrbW);
  localparam int unsigned IdxW     = AxiAddrWidth - AddrLsb;
  localparam int unsigned NumWords = (RegNumBytes + StrbW - 1) / StrbW;

  function automatic logic prot_ok(input logic [AXI_PROT_W-1:0] prot);
    return !(PrivProtOnly && !prot[0]) && !(SecuProtOnly && prot[1]);
  endfunction

  logic [RegNumBytes-1:0][7:0] reg_d, reg_q;
  logic [RegNumBytes-1:0]      wr_sel, wr_ro, wr_hit, rd_hit;
  logic [RegNumBytes-1:0]      wr_active_q, rd_active_q;
  logic [IdxW-1:0]             aw_idx, ar_idx;
  logic                        wr_accept, rd_accept, wr_ok, rd_ok, wr_err;
  logic                        b_valid, r_valid;
  logic [AxiDataWidth-1:0]     rd_data;
  b_chan_t                     b_d, b_q;
  r_chan_t                     r_d, r_q;
  logic                        unused_bits;

  assign aw_idx = axi_req_i.aw.addr[AxiAddrWidth-1:AddrLsb];
  assign ar_idx = axi_req_i.ar.addr[AxiAddrWidth-1:AddrLsb];
  assign unused_bits = ^{axi_req_i.aw.addr[AddrLsb-1:0], axi_req_i.ar.addr[AddrLsb-1:0],
                         axi_req_i.aw.prot[2], axi_req_i.ar.prot[2]};

  // AW and W are only ever taken together, and only when B has room.
  assign wr_accept = axi_req_i.aw_valid && axi_req_i.w_valid && (!b_valid || axi_req_i.b_ready);
  assign rd_accept = axi_req_i.ar_valid && (!r_valid || axi_req_i.r_ready);
  assign wr_ok     = (aw_idx < IdxW'(NumWords)) && prot_ok(axi_req_i.aw.prot);
  assign rd_ok     = (ar_idx < IdxW'(NumWords)) && prot_ok(axi_req_i.ar.prot);
  assign wr_err    = !wr_ok || (|wr_ro);

  // Per-byte lane arbitration: hardware load beats a same-cycle bus write.
  for (genvar b = 0; b < RegNumBytes; b++) begin : g_byte
    localparam int unsigned Word = b / StrbW;
    localparam int unsigned Lane = b % StrbW;
    assign wr_sel[b] = (aw_idx == IdxW'(Word)) && axi_req_i.w.strb[Lane];
    assign wr_ro[b]  = wr_sel[b] && AxiReadOnly[b];
    assign wr_hit[b] = wr_accept && wr_ok && wr_sel[b] && !AxiReadOnly[b];
    assign rd_hit[b] = rd_accept && rd_ok && (ar_idx == IdxW'(Word));
    assign reg_d[b]  = reg_load_i[b] ? reg_d_i[b*8 +: 8] :
                       wr_hit[b]     ? axi_req_i.w.data[Lane*8 +: 8] : reg_q[b];
  end

  // Bytes past the end of the bank in a partial last word stay zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned b = 0; b < RegNumBytes; b++) begin
      if (ar_idx == IdxW'(b / StrbW)) rd_data[(b % StrbW)*8 +: 8] = reg_q[b];
    end
    if (!rd_ok) rd_data = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q       <= RegRstVal;
      wr_active_q <= '0;
      rd_active_q <= '0;
    end else begin
      reg_q       <= reg_d;
      wr_active_q <= wr_hit;
      rd_active_q <= rd_hit;
    end
  end

  always_comb begin
    b_d      = '0;
    b_d.resp = wr_err ? RESP_SLVERR : RESP_OKAY;
    r_d      = '0;
    r_d.data = rd_data;
    r_d.resp = rd_ok ? RESP_OKAY : RESP_SLVERR;
  end

  axi_lite_reg_slv_rsp_hold #(.payload_t(b_chan_t)) u_b_hold (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .accept_i  (wr_accept),
    .payload_i (b_d),
    .ready_i   (axi_req_i.b_ready),
    .valid_o   (b_valid),
    .payload_o (b_q)
  );

  axi_lite_reg_slv_rsp_hold #(.payload_t(r_chan_t)) u_r_hold (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .accept_i  (rd_accept),
    .payload_i (r_d),
    .ready_i   (axi_req_i.r_ready),
    .valid_o   (r_valid),
    .payload_o (r_q)
  );

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = wr_accept;
    axi_resp_o.w_ready  = wr_accept;
    axi_resp_o.b        = b_q;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.ar_ready = rd_accept;
    axi_resp_o.r        = r_q;
    axi_resp_o.r_valid  = r_valid;
  end

  assign wr_active_o = wr_active_q;
  assign rd_active_o = rd_active_q;
  assign reg_q_o     = reg_q;

endmodule

// File: tb/tb_axi_lite_reg_slv.sv
// Directed bench for axi_lite_reg_slv: 32-byte bank, byte 8 read-only,
// privileged-only access, reset bytes 0..3 = 11 22 33 44.
module tb_axi_lite_reg_slv;
  import axi_lite_reg_slv_pkg::*;

  logic           clk, rst_n;
  axi_lite_req_t  req;
  axi_lite_resp_t rsp;
  logic [31:0]    wr_active, rd_active;
  logic [255:0]   reg_d, reg_q;
  logic [31:0]    reg_load;
  logic [255:0]   exp_q;
  int             n_cmp = 0;
  int             n_mis = 0;

  axi_lite_reg_slv #(
    .RegNumBytes  (32),
    .AxiAddrWidth (32),
    .AxiDataWidth (32),
    .PrivProtOnly (1'b1),
    .SecuProtOnly (1'b0),
    .AxiReadOnly  (32'h0000_0100),
    .RegRstVal    (256'h4433_2211)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req),
    .axi_resp_o  (rsp),
    .wr_active_o (wr_active),
    .rd_active_o (rd_active),
    .reg_d_i     (reg_d),
    .reg_load_i  (reg_load),
    .reg_q_o     (reg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input logic [31:0] exp_act, input logic [1:0] exp_resp);
    int n;
    req.aw.addr = addr;  req.aw.prot = prot;
    req.w.data  = data;  req.w.strb  = strb;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp.aw_ready && n < 20);
    check({tag, "_awrdy"}, 256'(rsp.aw_ready && rsp.w_ready), 256'd1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    check({tag, "_wract"}, 256'(wr_active), 256'(exp_act));
    check({tag, "_bvalid"}, 256'(rsp.b_valid), 256'd1);
    check({tag, "_bresp"}, 256'(rsp.b.resp), 256'(exp_resp));
    @(posedge clk); #1;
    check({tag, "_bdone"}, 256'(rsp.b_valid), 256'd0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input logic [31:0] exp_ract);
    int n;
    req.ar.addr = addr; req.ar.prot = prot;
    req.ar_valid = 1'b1; req.r_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp.ar_ready && n < 20);
    check({tag, "_arrdy"}, 256'(rsp.ar_ready), 256'd1);
    check({tag, "_rpre"}, 256'(rsp.r_valid), 256'd0);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    check({tag, "_rvalid"}, 256'(rsp.r_valid), 256'd1);
    check({tag, "_rdata"}, 256'(rsp.r.data), 256'(exp_data));
    check({tag, "_rresp"}, 256'(rsp.r.resp), 256'(exp_resp));
    check({tag, "_rdact"}, 256'(rd_active), 256'(exp_ract));
    @(posedge clk); #1;
    check({tag, "_rdone"}, 256'(rsp.r_valid), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    req = '0; rst_n = 1'b0; reg_load = '0; reg_d = '0;
    exp_q = 256'h4433_2211;
    repeat (3) @(posedge clk);
    #1;
    check("rst_regq", reg_q, exp_q);
    check("rst_bvalid", 256'(rsp.b_valid), 256'd0);
    check("rst_rvalid", 256'(rsp.r_valid), 256'd0);
    check("rst_ready", 256'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready}), 256'd0);
    check("rst_act", 256'({wr_active, rd_active}), 256'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_read("rd0", 32'h0, 3'b001, 32'h4433_2211, RESP_OKAY, 32'h0000_000F);

    do_write("wr4", 32'h4, 32'hDEAD_BEEF, 4'b0101, 3'b001, 32'h0000_0050, RESP_OKAY);
    exp_q[39:32] = 8'hEF; exp_q[55:48] = 8'hAD;
    check("wr4_regq", reg_q, exp_q);
    do_read("rd4", 32'h4, 3'b001, 32'h00AD_00EF, RESP_OKAY, 32'h0000_00F0);

    do_write("wr8", 32'h8, 32'hFFFF_FFFF, 4'hF, 3'b001, 32'h0000_0E00, RESP_SLVERR);
    exp_q[95:72] = 24'hFF_FFFF;
    check("wr8_regq", reg_q, exp_q);
    do_read("rd8", 32'h8, 3'b001, 32'hFFFF_FF00, RESP_OKAY, 32'h0000_0F00);

    do_write("wr20", 32'h20, 32'h1234_5678, 4'hF, 3'b001, 32'h0, RESP_SLVERR);
    check("wr20_regq", reg_q, exp_q);
    do_read("rd20", 32'h20, 3'b001, 32'h0, RESP_SLVERR, 32'h0);

    do_write("wrprot", 32'h0, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, RESP_SLVERR);
    check("wrprot_regq", reg_q, exp_q);
    do_read("rdprot", 32'h0, 3'b000, 32'h0, RESP_SLVERR, 32'h0);

    do_write("wrz", 32'hC, 32'hFFFF_FFFF, 4'h0, 3'b001, 32'h0, RESP_OKAY);
    check("wrz_regq", reg_q, exp_q);

    // B back-pressure: second AW+W waits until the first B is taken
    req.aw.addr = 32'hC; req.aw.prot = 3'b001; req.w.data = 32'hCAFE_F00D; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
    @(negedge clk);
    check("stall_first_rdy", 256'(rsp.aw_ready), 256'd1);
    @(posedge clk); #1;
    exp_q[127:96] = 32'hCAFE_F00D;
    req.aw.addr = 32'h10; req.w.data = 32'h0102_0304;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_awrdy", 256'({rsp.aw_ready, rsp.w_ready}), 256'd0);
      check("stall_bvalid", 256'(rsp.b_valid), 256'd1);
    end
    req.b_ready = 1'b1;
    #1;
    check("stall_release_rdy", 256'({rsp.aw_ready, rsp.w_ready}), 256'd3);
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    exp_q[159:128] = 32'h0102_0304;
    check("stall_b2_valid", 256'(rsp.b_valid), 256'd1);
    check("stall_b2_resp", 256'(rsp.b.resp), 256'(RESP_OKAY));
    check("stall_b2_act", 256'(wr_active), 256'h000F_0000);
    @(posedge clk); #1;
    check("stall_b2_done", 256'(rsp.b_valid), 256'd0);
    check("stall_regq", reg_q, exp_q);

    // Hardware load collides with a bus write on byte 0
    reg_d[7:0] = 8'h55; reg_load[0] = 1'b1;
    do_write("coll", 32'h0, 32'h0000_00AA, 4'b0001, 3'b001, 32'h0000_0001, RESP_OKAY);
    reg_load = '0;
    exp_q[7:0] = 8'h55;
    check("coll_regq", reg_q, exp_q);
    do_read("coll_rd", 32'h0, 3'b001, 32'h4433_2255, RESP_OKAY, 32'h0000_000F);

    reg_d[167:160] = 8'h5A; reg_load[20] = 1'b1;
    @(posedge clk); #1;
    reg_load = '0;
    exp_q[167:160] = 8'h5A;
    check("hwld_regq", reg_q, exp_q);
    check("hwld_wract", 256'(wr_active), 256'd0);

    // Same-cycle read and write of one word: read sees the old value
    req.aw.addr = 32'h4; req.aw.prot = 3'b001; req.w.data = 32'h1234_5678; req.w.strb = 4'hF;
    req.ar.addr = 32'h4; req.ar.prot = 3'b001;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    req.b_ready = 1'b1; req.r_ready = 1'b1;
    @(negedge clk);
    check("rw_rdy", 256'({rsp.aw_ready, rsp.ar_ready}), 256'd3);
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    exp_q[63:32] = 32'h1234_5678;
    check("rw_rdata", 256'(rsp.r.data), 256'h00AD_00EF);
    check("rw_bresp", 256'({rsp.b_valid, rsp.b.resp}), 256'({1'b1, RESP_OKAY}));
    @(posedge clk); #1;
    check("rw_regq", reg_q, exp_q);

    // Reset with a B pending drops it and restores the bank
    req.aw.addr = 32'h0; req.w.data = 32'hFFFF_FFFF; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b0;
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    check("mid_bvalid", 256'(rsp.b_valid), 256'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", 256'(rsp.b_valid), 256'd0);
    check("mid_rst_regq", reg_q, 256'h4433_2211);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_slv.md
Name: axi_lite_reg_slv

Overview:
AXI4-Lite responder that terminates one master port of the AXI4-Lite crossbar. It holds a byte-addressable register bank and serves bus reads and writes with per-byte strobes, read-only byte masks and PROT checking. It exposes all register bytes to hardware, and hardware can load any byte directly. It is the subordinate end of the same request/response structs the crossbar drives.

Parameters:
RegNumBytes, 32, number of register bytes in the bank; must be ≥1.
AxiAddrWidth, 32, AXI-Lite address width.
AxiDataWidth, 32, AXI-Lite data width; must be 32 or 64.
PrivProtOnly, 1'b0, when set, accesses with prot[0]=0 (unprivileged) are refused with SLVERR.
SecuProtOnly, 1'b0, when set, accesses with prot[1]=1 (non-secure) are refused with SLVERR.
AxiReadOnly, '0 [RegNumBytes-1:0], per-byte mask; a set bit makes that byte unwritable from the bus.
RegRstVal, '0 [RegNumBytes-1:0][7:0], per-byte reset value.
req_lite_t, logic, AXI-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
resp_lite_t, logic, AXI-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
axi_req_i  in  req_lite_t  AXI-Lite request from the crossbar master port
axi_resp_o  out  resp_lite_t  AXI-Lite response
wr_active_o  out  RegNumBytes  one-cycle pulse per byte written by the bus
rd_active_o  out  RegNumBytes  one-cycle pulse per byte read by the bus
reg_d_i  in  RegNumBytes*8  hardware load data
reg_load_i  in  RegNumBytes  per-byte hardware load enable
reg_q_o  out  RegNumBytes*8  current register bank contents

Behaviour:
- Reset: reg_q_o=RegRstVal; b_valid=0, r_valid=0; aw_ready=w_ready=ar_ready=0; wr_active_o=rd_active_o=0.
- Addressing: the word index is addr / (AxiDataWidth/8); low address bits are ignored. Byte k of the word maps to bank byte index*(AxiDataWidth/8)+k. A word is out of range if its first byte index ≥ RegNumBytes. Bytes of a partial last word that lie past RegNumBytes read as 0 and are never written.
- Write accept: AW and W are accepted only together. aw_ready=w_ready=1 exactly when aw_valid && w_valid && (!b_valid || b_ready). No skid buffering; either channel may wait for the other.
- Write effect on the accept edge, for byte k with strb[k]=1:
  - If in range, not read-only and PROT passes, the byte is updated and wr_active_o[byte]=1 for that cycle only.
  - If hardware reg_load_i is set for the same byte in the same cycle, hardware wins. wr_active_o still pulses and the response is unaffected.
- B response: registered; b_valid=1 the cycle after accept and held with b.resp stable until b_ready.
  - resp=SLVERR if the address is out of range, PROT fails, or any strobed in-range byte is read-only.
  - Otherwise OKAY. A write with strb=0 returns OKAY and writes nothing.
  - PROT-failed and out-of-range writes modify no byte. Read-only bytes are skipped; other strobed bytes in the same word are still written.
- Read accept: ar_ready=1 when ar_valid && (!r_valid || r_ready). Data is sampled from the bank on the accept edge, reflecting the value before any same-cycle write. rd_active_o pulses for the bytes of in-range words.
- R response: r_valid the cycle after accept, held with data and resp stable until r_ready. Out-of-range or PROT fail gives data=0 and resp=SLVERR.
- Independence: read and write paths are independent and may accept in the same cycle. Back-to-back throughput is 1 transaction/cycle per direction when the ready is held high.
- Hardware load: reg_q_o reflects a load one cycle after reg_load_i is sampled. A load is independent of bus activity.
- Reset mid-transaction clears pending B/R. The master must reissue.

Decomposition:
- axi_pkg supplies RESP_OKAY/RESP_SLVERR. No new package types are needed; structs come in via the typedef macros.
- The byte-lane write/load arbitration is a generate loop, not a separate module.
- One natural sub-module, axi_lite_reg_slv_rsp_hold, holds the valid/payload register for a response channel. It is instantiated once for B and once for R.

Test Plan:
- Reset then read addr 0x0 with RegRstVal byte0..3=0x11,0x22,0x33,0x44 -> r.data=0x44332211, resp OKAY, r_valid exactly 1 cycle after ar handshake.
- Write 0xDEADBEEF strb=0b0101 to 0x4 (RegRstVal 0) -> B OKAY; read 0x4 returns 0x00AD00EF; wr_active_o pulses only on bytes 4 and 6.
- AxiReadOnly[8]=1, write 0xFFFFFFFF strb=0xF to 0x8 -> B SLVERR; read 0x8 returns 0xFFFFFF00 (bytes 9..11 written, byte 8 keeps reset 0).
- Write to 0x20 with RegNumBytes=32 -> B SLVERR, no byte changes; read 0x20 -> data 0, SLVERR.
- Hold b_ready=0 for 5 cycles after a write while a second AW+W stays valid -> aw_ready/w_ready stay 0 until the b_ready handshake, then accept in that same cycle; the second B follows one cycle later.
- Same-cycle bus write 0xAA and reg_load_i with 0x55 to byte 0 -> reg_q_o byte0=0x55, B OKAY. PrivProtOnly=1 with ar.prot=3'b000 -> SLVERR, data 0.
